// File: rtl/mdrv_pkg.sv
// Shared types for the mdriver request sequencer: FSM states and the buffered request record.
package mdrv_pkg;

  localparam int unsigned MDRV_ADDR_W = 8;
  localparam int unsigned MDRV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } mdrv_state_t;

  typedef struct packed {
    logic                   we;
    logic [MDRV_ADDR_W-1:0] addr;
    logic [MDRV_DATA_W-1:0] data;
  } mdrv_req_t;

endpackage

// File: rtl/mdrv_req_fifo.sv
// Request FIFO with a combinational head; pointers carry one extra wrap bit to tell full from empty.
module mdrv_req_fifo
  import mdrv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic                     pop,
  input  mdrv_req_t                din,
  output mdrv_req_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  mdrv_req_t      mem_q [DEPTH];
  logic [AW:0]    wptr_q, wptr_d;
  logic [AW:0]    rptr_q, rptr_d;
  logic           wr_en;
  logic           rd_en;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign count = wptr_q - rptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr_q == rptr_q);
  assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mdriver_req_sequencer.sv
// Core-side request front-end: queues requests, issues them one at a time to mdriver_int,
// and returns each completion (or timeout error) on a valid/ready response channel.
module mdriver_req_sequencer
  import mdrv_pkg::*;
#(
  parameter int unsigned DATA_W  = MDRV_DATA_W,
  parameter int unsigned ADDR_W  = MDRV_ADDR_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] si_address,
  output logic [DATA_W-1:0] si_data,
  output logic              we,
  output logic              exec,
  input  logic [DATA_W-1:0] so_data,
  input  logic              fin,
  output logic              busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mdrv_state_t        state_q, state_d;
  logic               exec_q, exec_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  sdata_q, sdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [TW-1:0]      tmo_q, tmo_d;

  mdrv_req_t              fifo_din;
  mdrv_req_t              fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;

  always_comb begin
    fifo_din      = '0;
    fifo_din.we   = req_we;
    fifo_din.addr = req_addr;
    fifo_din.data = req_data;
  end

  mdrv_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (req_valid && !fifo_full),
    .pop    (fifo_pop),
    .din    (fifo_din),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    exec_d      = exec_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = fifo_head.we;
          addr_d   = fifo_head.addr;
          sdata_d  = fifo_head.we ? fifo_head.data : '0;
          exec_d   = 1'b1;
          tmo_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // fin wins over a timeout landing on the same cycle.
        if (fin) begin
          exec_d     = 1'b0;
          rsp_data_d = we_q ? '0 : so_data;
          rsp_we_d   = we_q;
          rsp_err_d  = 1'b0;
          state_d    = DRAIN;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          exec_d     = 1'b0;
          rsp_data_d = '0;
          rsp_we_d   = we_q;
          rsp_err_d  = 1'b1;
          state_d    = DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!fin) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      exec_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      exec_q      <= exec_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req_ready  = !fifo_full;
  assign exec       = exec_q;
  assign we         = we_q;
  assign si_address = addr_q;
  assign si_data    = sdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_we     = rsp_we_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_mdriver_req_sequencer.sv
// Directed bench for mdriver_req_sequencer with a small mdriver_int/memory responder model.
module tb_mdriver_req_sequencer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              nreset;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] si_address;
  logic [DATA_W-1:0] si_data, so_data;
  logic              we, exec, fin, busy;

  always #5 clk = ~clk;

  mdriver_req_sequencer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_we     (rsp_we),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .si_address (si_address),
    .si_data    (si_data),
    .we         (we),
    .exec       (exec),
    .so_data    (so_data),
    .fin        (fin),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: after exec rises, waits lat cycles then pulses fin for one cycle.
  logic [31:0] mem [256];
  int lat = 0;
  bit stuck = 1'b0;
  int lat_cnt = 0;

  initial begin
    fin = 1'b0;
    so_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (!nreset || stuck) begin
        fin = 1'b0;
        lat_cnt = 0;
      end else if (fin) begin
        fin = 1'b0;
        lat_cnt = 0;
      end else if (exec) begin
        if (lat_cnt >= lat) begin
          fin = 1'b1;
          if (we) begin
            mem[si_address] = si_data;
            so_data = 32'hBADC0FFE;
          end else begin
            so_data = mem[si_address];
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t rq[$];
  rsp_t cur, p_rsp;
  int   viol_fin = 0, viol_we = 0, viol_stab = 0;
  logic p_fin = 1'b0, p_exec = 1'b0, p_we = 1'b0, p_stall = 1'b0;

  always @(negedge clk) begin
    cur.we   = rsp_we;
    cur.data = rsp_data;
    cur.err  = rsp_err;
    if (nreset) begin
      if (p_fin && exec) viol_fin++;
      if (p_exec && exec && (we != p_we)) viol_we++;
      if (p_stall && (!rsp_valid || cur != p_rsp)) viol_stab++;
      if (rsp_valid && rsp_ready) rq.push_back(cur);
    end
    p_fin   = fin;
    p_exec  = exec;
    p_we    = we;
    p_stall = nreset && rsp_valid && !rsp_ready;
    p_rsp   = cur;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input string name, input logic w, input logic [7:0] a, input logic [31:0] d);
    logic rdy;
    int n = 0;
    req_valid = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_data  = d;
    do begin
      rdy = req_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    req_valid = 1'b0;
    chk({name, "_accepted"}, rdy, 1);
  endtask

  task automatic get_rsp(input string name, input logic ew, input logic [31:0] ed, input logic ee);
    int n = 0;
    rsp_t r;
    while (rq.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_arrived"}, rq.size() != 0, 1);
    if (rq.size() != 0) begin
      r = rq.pop_front();
      chk({name, "_we"},   r.we,   ew);
      chk({name, "_data"}, r.data, ed);
      chk({name, "_err"},  r.err,  ee);
    end
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    int          lat;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'h22, 32'h12345678, 1, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 8'h22, 32'hFFFF0000, 0, 1'b0, 32'h12345678};
    vecs[2] = '{1'b1, 8'h05, 32'hA5A50005, 3, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 8'h05, 32'h0F0F0F0F, 2, 1'b0, 32'hA5A50005};
    vecs[4] = '{1'b0, 8'h10, 32'h0,        1, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 8'hFF, 32'h13572468, 5, 1'b0, 32'hFFFFFFFF};
    vecs[7] = '{1'b0, 8'h00, 32'hCAFEF00D, 0, 1'b0, 32'h0};

    nreset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec", exec, 0);
    chk("rst_we", we, 0);
    chk("rst_si_address", si_address, 0);
    chk("rst_si_data", si_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    nreset = 1'b1;
    tick();

    // Single write with exact issue latency.
    lat = 2;
    push("wr1", 1'b1, 8'h10, 32'hDEADBEEF);
    chk("wr1_exec_cycle1", exec, 0);
    tick();
    chk("wr1_exec_cycle2", exec, 1);
    chk("wr1_we", we, 1);
    chk("wr1_addr", si_address, 8'h10);
    chk("wr1_data", si_data, 32'hDEADBEEF);
    get_rsp("wr1", 1'b1, 32'h0, 1'b0);
    chk("wr1_mem", mem[8'h10], 32'hDEADBEEF);

    for (int i = 0; i < 8; i++) begin
      lat = vecs[i].lat;
      push($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data);
      tick();
      chk($sformatf("vec%0d_exec", i), exec, 1);
      chk($sformatf("vec%0d_we_out", i), we, vecs[i].we);
      chk($sformatf("vec%0d_si_address", i), si_address, vecs[i].addr);
      chk($sformatf("vec%0d_si_data", i), si_data, vecs[i].we ? vecs[i].data : 32'h0);
      get_rsp($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_data, 1'b0);
    end

    // FIFO fills while the first completion is stalled.
    rsp_ready = 1'b0;
    lat = 0;
    push("full0", 1'b1, 8'h40, 32'h11111111);
    push("full1", 1'b1, 8'h41, 32'h22222222);
    push("full2", 1'b0, 8'h40, 32'h0);
    push("full3", 1'b0, 8'h41, 32'h0);
    push("full4", 1'b0, 8'h22, 32'h0);
    chk("full_req_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    repeat (3) tick();
    chk("full_req_ready_held", req_ready, 0);
    chk("full_exec_idle", exec, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    get_rsp("full_r0", 1'b1, 32'h0, 1'b0);
    get_rsp("full_r1", 1'b1, 32'h0, 1'b0);
    get_rsp("full_r2", 1'b0, 32'h11111111, 1'b0);
    get_rsp("full_r3", 1'b0, 32'h22222222, 1'b0);
    get_rsp("full_r4", 1'b0, 32'h12345678, 1'b0);

    // Response backpressure with a second request waiting.
    rsp_ready = 1'b0;
    lat = 1;
    push("bp_rd", 1'b0, 8'h05, 32'h0);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("bp_rsp_valid_seen", rsp_valid, 1);
    push("bp_wr", 1'b1, 8'h06, 32'h55AA55AA);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_c%0d_valid", c), rsp_valid, 1);
      chk($sformatf("bp_c%0d_data", c), rsp_data, 32'hA5A50005);
      chk($sformatf("bp_c%0d_exec", c), exec, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_exec", exec, 0);
    chk("bp_hs_valid", rsp_valid, 0);
    tick();
    chk("bp_next_exec", exec, 1);
    chk("bp_next_addr", si_address, 8'h06);
    get_rsp("bp_rd", 1'b0, 32'hA5A50005, 1'b0);
    get_rsp("bp_wr", 1'b1, 32'h0, 1'b0);

    // Timeout: responder never answers the first request.
    stuck = 1'b1;
    push("tmo_rd", 1'b0, 8'h07, 32'h0);
    push("tmo_wr", 1'b1, 8'h08, 32'h08080808);
    n = 0;
    while (exec && n < 200) begin n++; tick(); end
    chk("tmo_exec_cycles", n, 64);
    stuck = 1'b0;
    get_rsp("tmo_rd", 1'b0, 32'h0, 1'b1);
    get_rsp("tmo_wr", 1'b1, 32'h0, 1'b0);
    chk("tmo_wr_mem", mem[8'h08], 32'h08080808);

    // Stray fin while idle.
    repeat (2) tick();
    #1 fin = 1'b1;
    repeat (3) tick();
    chk("idle_fin_busy", busy, 0);
    chk("idle_fin_exec", exec, 0);
    chk("idle_fin_no_rsp", rq.size(), 0);

    // Reset during ISSUE with two requests queued.
    stuck = 1'b1;
    push("rst_q0", 1'b1, 8'h50, 32'h1);
    push("rst_q1", 1'b1, 8'h51, 32'h2);
    push("rst_q2", 1'b1, 8'h52, 32'h3);
    chk("rst_mid_exec_before", exec, 1);
    chk("rst_mid_busy_before", busy, 1);
    #3 nreset = 1'b0;
    #1;
    chk("rst_mid_exec", exec, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #4 nreset = 1'b1;
    stuck = 1'b0;
    tick();
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (20) tick();
    chk("rst_mid_no_rsp", rq.size(), 0);
    chk("rst_mid_exec_after", exec, 0);
    chk("rst_mid_mem", mem[8'h50], 32'h0);

    chk("exec_after_fin", viol_fin, 0);
    chk("we_stable_during_exec", viol_we, 0);
    chk("rsp_stable_under_backpressure", viol_stab, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
